// File: rtl/game_pkg.sv
// Shared game constants and state codes used by the sequencer, renderer and physics block.
package game_pkg;

  typedef enum logic [2:0] {
    S_RUNNING   = 3'd0,
    S_GAME_OVER = 3'd1,
    S_WIN       = 3'd2,
    S_READY     = 3'd3
  } game_state_t;

  localparam int LAVA_Y      = 380;
  localparam int PLAYER_SIZE = 16;
  localparam int WALL_WIDTH  = 10;
  localparam int GOAL_X0     = 580;
  localparam int GOAL_X1     = 630;
  localparam int GOAL_Y      = 355;
  localparam int SCREEN_W    = 640;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector: one delay flop and an AND, pulse is combinational.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise
);

  logic level_d;

  always_ff @(posedge clk) begin
    if (rst) level_d <= 1'b0;
    else     level_d <= level;
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/game_sequencer.sv
// Frame-rate game FSM: advances the lava wall and resolves death/win once per frame tick.
module game_sequencer #(
  parameter logic [9:0] WALL_START_X     = 10'd0,
  parameter int         WALL_WIDTH       = game_pkg::WALL_WIDTH,
  parameter int         WALL_STEP_FRAMES = 4,
  parameter int         PLAYER_SIZE      = game_pkg::PLAYER_SIZE,
  parameter int         LAVA_Y           = game_pkg::LAVA_Y,
  parameter int         GOAL_X0          = game_pkg::GOAL_X0,
  parameter int         GOAL_X1          = game_pkg::GOAL_X1,
  parameter int         GOAL_Y           = game_pkg::GOAL_Y,
  parameter int         END_HOLD_FRAMES  = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic [9:0] player_x,
  input  logic [9:0] player_y,
  output logic [2:0] game_state,
  output logic [9:0] lava_wall_x,
  output logic       player_reset
);

  import game_pkg::*;

  localparam logic [15:0] STEP_LAST = 16'(WALL_STEP_FRAMES - 1);
  localparam logic [15:0] HOLD_LAST = 16'(END_HOLD_FRAMES - 1);
  localparam logic [9:0]  WALL_MAX  = 10'(SCREEN_W - WALL_WIDTH);

  game_state_t state_q;
  logic [9:0]  wall_q;
  logic [15:0] step_cnt;
  logic [15:0] hold_cnt;
  logic        start_pending;
  logic        start_rise;
  logic        preset_q;

  logic [10:0] px, wall_edge, py_bot, px_right;
  logic        death, win;

  rise_detect u_start_edge (
    .clk   (clk),
    .rst   (rst),
    .level (start_btn),
    .rise  (start_rise)
  );

  // Positions widened to 11 bits so the sums never wrap.
  always_comb begin
    px        = {1'b0, player_x};
    wall_edge = {1'b0, wall_q} + 11'(WALL_WIDTH);
    py_bot    = {1'b0, player_y} + 11'(PLAYER_SIZE);
    px_right  = px + 11'(PLAYER_SIZE);
    death     = (px < wall_edge) || (py_bot > 11'(LAVA_Y));
    win       = (px_right > 11'(GOAL_X0)) && (px <= 11'(GOAL_X1)) &&
                (py_bot >= 11'(GOAL_Y)) && (py_bot <= 11'(GOAL_Y + 5));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_READY;
      wall_q        <= WALL_START_X;
      step_cnt      <= '0;
      hold_cnt      <= '0;
      start_pending <= 1'b0;
      preset_q      <= 1'b0;
    end else begin
      preset_q <= 1'b0;
      if (start_rise && (state_q == S_READY || state_q == S_RUNNING))
        start_pending <= 1'b1;

      if (frame_tick) begin
        case (state_q)
          S_READY: begin
            wall_q <= WALL_START_X;
            if (start_pending) begin
              state_q       <= S_RUNNING;
              start_pending <= 1'b0;
              step_cnt      <= '0;
              preset_q      <= 1'b1;
            end
          end
          S_RUNNING: begin
            if (death || win) begin
              state_q       <= death ? S_GAME_OVER : S_WIN;
              hold_cnt      <= '0;
              start_pending <= 1'b0;
            end else if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              if (wall_q < WALL_MAX) wall_q <= wall_q + 10'd1;
            end else begin
              step_cnt <= step_cnt + 16'd1;
            end
          end
          S_GAME_OVER, S_WIN: begin
            start_pending <= 1'b0;
            if (hold_cnt == HOLD_LAST) begin
              state_q  <= S_READY;
              wall_q   <= WALL_START_X;
              hold_cnt <= '0;
              preset_q <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + 16'd1;
            end
          end
          default: state_q <= S_READY;
        endcase
      end else if (state_q == S_GAME_OVER || state_q == S_WIN) begin
        start_pending <= 1'b0;
      end
    end
  end

  assign game_state   = state_q;
  assign lava_wall_x  = wall_q;
  assign player_reset = preset_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with default parameters.
module tb_game_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic [9:0] player_x = 10'd300;
  logic [9:0] player_y = 10'd200;
  logic [2:0] game_state;
  logic [9:0] lava_wall_x;
  logic       player_reset;

  int n_tests = 0;
  int n_fail  = 0;

  game_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .start_btn    (start_btn),
    .player_x     (player_x),
    .player_y     (player_y),
    .game_state   (game_state),
    .lava_wall_x  (lava_wall_x),
    .player_reset (player_reset)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Single tick cycle; returns at the following negedge, when player_reset is visible.
  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      @(negedge clk);
    end
  endtask

  task automatic press();
    start_btn = 1'b1;
    @(negedge clk);
    start_btn = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_state", 32'(game_state), 32'd3);
    check("reset_wall", 32'(lava_wall_x), 32'd0);
    check("reset_preset", 32'(player_reset), 32'd0);

    tick();
    check("idle_tick_state", 32'(game_state), 32'd3);
    check("idle_tick_preset", 32'(player_reset), 32'd0);
    @(negedge clk);

    press();
    tick();
    check("start_state", 32'(game_state), 32'd0);
    check("start_preset_pulse", 32'(player_reset), 32'd1);
    @(negedge clk);
    check("start_preset_end", 32'(player_reset), 32'd0);

    ticks(8);
    check("wall_after_8", 32'(lava_wall_x), 32'd2);

    ticks(392);
    check("wall_at_100", 32'(lava_wall_x), 32'd100);
    player_x = 10'd110;
    ticks(1);
    check("wall_edge_safe", 32'(game_state), 32'd0);
    player_x = 10'd109;
    ticks(1);
    check("wall_death_state", 32'(game_state), 32'd1);
    check("wall_death_no_step", 32'(lava_wall_x), 32'd100);

    for (int i = 0; i < 119; i++) begin
      if (i % 10 == 3) begin
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
      end
      ticks(1);
    end
    check("hold_119_state", 32'(game_state), 32'd1);
    check("hold_wall_frozen", 32'(lava_wall_x), 32'd100);
    tick();
    check("hold_done_state", 32'(game_state), 32'd3);
    check("hold_done_wall", 32'(lava_wall_x), 32'd0);
    check("hold_done_preset", 32'(player_reset), 32'd1);
    @(negedge clk);
    check("hold_done_preset_end", 32'(player_reset), 32'd0);
    ticks(1);
    check("presses_ignored", 32'(game_state), 32'd3);

    player_x = 10'd300;
    player_y = 10'd364;
    press();
    ticks(1);
    check("restart_state", 32'(game_state), 32'd0);
    ticks(1);
    check("lava_edge_safe", 32'(game_state), 32'd0);
    player_y = 10'd365;
    ticks(1);
    check("lava_death", 32'(game_state), 32'd1);
    ticks(120);
    check("lava_back_ready", 32'(game_state), 32'd3);

    player_x = 10'd600;
    player_y = 10'd345;
    press();
    ticks(1);
    ticks(1);
    check("goal_too_low", 32'(game_state), 32'd0);
    player_y = 10'd339;
    ticks(1);
    check("win_state", 32'(game_state), 32'd2);
    ticks(120);
    check("win_back_ready", 32'(game_state), 32'd3);

    player_x = 10'd1000;
    player_y = 10'd200;
    press();
    ticks(1);
    ticks(2519);
    check("wall_2519", 32'(lava_wall_x), 32'd629);
    ticks(1);
    check("wall_sat_2520", 32'(lava_wall_x), 32'd630);
    ticks(8);
    check("wall_sat_hold", 32'(lava_wall_x), 32'd630);
    player_x = 10'd600;
    player_y = 10'd339;
    ticks(1);
    check("death_over_win", 32'(game_state), 32'd1);
    ticks(120);
    check("prio_back_ready", 32'(game_state), 32'd3);

    player_x = 10'd300;
    player_y = 10'd200;
    start_btn  = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    start_btn  = 1'b0;
    frame_tick = 1'b0;
    check("same_cycle_ready", 32'(game_state), 32'd3);
    @(negedge clk);
    ticks(1);
    check("next_tick_running", 32'(game_state), 32'd0);

    ticks(228);
    check("wall_57", 32'(lava_wall_x), 32'd57);
    rst        = 1'b1;
    frame_tick = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    frame_tick = 1'b0;
    check("midrun_rst_state", 32'(game_state), 32'd3);
    check("midrun_rst_wall", 32'(lava_wall_x), 32'd0);
    check("midrun_rst_preset", 32'(player_reset), 32'd0);
    @(negedge clk);
    check("midrun_rst_preset2", 32'(player_reset), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
